// File: rtl/latch_xm_skid_pkg.sv
// Purpose: shared definitions for the X/M pipeline latch with skid buffer.
//   - occupancy encodings (EMPTY/ONE/FULL) built from {skid_valid, main_valid}
//   - default field widths and the default NOP instruction word
//   - payload width helper: IR + o + b + rStatus + isRStatus
package latch_xm_skid_pkg;

   localparam int unsigned XM_DATA_W_DEF = 32;
   localparam int unsigned XM_IR_W_DEF   = 32;

   localparam logic [XM_IR_W_DEF-1:0] XM_NOP_IR_DEF = '0;

   // Encoding equals {skid_valid, main_valid}; 2'b10 cannot occur.
   typedef enum logic [1:0] {
      XM_EMPTY = 2'b00,
      XM_ONE   = 2'b01,
      XM_FULL  = 2'b11
   } xm_state_e;

   function automatic int unsigned xm_payload_w(input int unsigned ir_w,
                                                input int unsigned data_w);
      return ir_w + 3 * data_w + 1;
   endfunction

endpackage

// File: rtl/latch_xm_skid_xm_slot.sv
// Purpose: one storage slot of the X/M latch: payload register with load
//   enable plus a valid flop with synchronous kill.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   load           capture d into the payload register
//   valid_in       next value of the valid bit (when not killed)
//   kill           forces the valid bit to 0 at the next edge
//   d              payload to capture
//   valid_out      registered valid bit
//   q_out          registered payload
module xm_slot #(
   parameter int unsigned W = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic         valid_in,
   input  logic         kill,
   input  logic [W-1:0] d,
   output logic         valid_out,
   output logic [W-1:0] q_out
);

   logic         valid_d, valid_q;
   logic [W-1:0] payload_d, payload_q;

   // Next-state: payload loads on demand, kill overrides the valid update.
   always_comb begin
      payload_d = payload_q;
      valid_d   = valid_in;
      if (load) payload_d = d;
      if (kill) valid_d   = 1'b0;
   end

   // Payload reset is only for deterministic simulation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign valid_out = valid_q;
   assign q_out     = payload_q;

endmodule

// File: rtl/latch_xm_skid.sv
// Purpose: execute->memory pipeline latch with valid/ready handshake, a
//   2-entry skid buffer (main + skid slot), synchronous flush and NOP
//   injection on bubbles. in_ready comes straight from a flop, so there is
//   no combinational path from out_ready to in_ready.
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready          upstream handshake (in_ready registered)
//   ir_in, o_in, b_in,
//   isRStatus_in, rStatus_in     execute-stage payload
//   flush                        synchronous kill of all held entries
//   out_valid / out_ready        downstream handshake
//   ir_out, o_out, b_out,
//   rStatus_out, isRStatus_out   main-slot payload; ir_out=NOP_IR and
//                                isRStatus_out=0 while out_valid=0
// Optional: define LATCH_XM_PERF_EN to add stall_cnt and flush_cnt outputs.
module latch_xm_skid
   import latch_xm_skid_pkg::*;
#(
   parameter int unsigned     DATA_W = XM_DATA_W_DEF,
   parameter int unsigned     IR_W   = XM_IR_W_DEF,
   parameter logic [IR_W-1:0] NOP_IR = IR_W'(XM_NOP_IR_DEF)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IR_W-1:0]   ir_in,
   input  logic [DATA_W-1:0] o_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              isRStatus_in,
   input  logic [DATA_W-1:0] rStatus_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IR_W-1:0]   ir_out,
   output logic [DATA_W-1:0] o_out,
   output logic [DATA_W-1:0] b_out,
   output logic [DATA_W-1:0] rStatus_out,
   output logic              isRStatus_out
`ifdef LATCH_XM_PERF_EN
  ,output logic [31:0]       stall_cnt
  ,output logic [31:0]       flush_cnt
`endif
);

   localparam int unsigned PAYLOAD_W = xm_payload_w(IR_W, DATA_W);
   // Field positions inside the packed payload {ir, o, b, rStatus, isRStatus}.
   localparam int unsigned IR_MSB = PAYLOAD_W - 1;
   localparam int unsigned O_MSB  = 3 * DATA_W;
   localparam int unsigned B_MSB  = 2 * DATA_W;
   localparam int unsigned RS_MSB = DATA_W;

   logic [PAYLOAD_W-1:0] in_payload, main_d, main_q, skid_q;
   logic                 main_valid, skid_valid;
   logic                 main_load, main_from_skid, main_vin;
   logic                 skid_load, skid_vin;
   logic                 acc, deq;
   logic                 in_ready_d, in_ready_q;
   xm_state_e            state;

   assign in_payload = {ir_in, o_in, b_in, rStatus_in, isRStatus_in};
   assign state      = xm_state_e'({skid_valid, main_valid});

   // Occupancy control: decide which slot loads and the next valid bits.
   always_comb begin
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_vin       = main_valid;
      skid_load      = 1'b0;
      skid_vin       = skid_valid;
      acc            = in_valid & in_ready_q;
      deq            = main_valid & out_ready;
      case (state)
         XM_EMPTY: begin
            if (acc) begin
               main_load = 1'b1;
               main_vin  = 1'b1;
            end
         end
         XM_ONE: begin
            if (acc && deq) begin
               main_load = 1'b1;
            end else if (acc) begin
               skid_load = 1'b1;
               skid_vin  = 1'b1;
            end else if (deq) begin
               main_vin  = 1'b0;
            end
         end
         XM_FULL: begin
            // in_ready is 0 here, so only the skid->main promotion happens.
            if (deq) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               skid_vin       = 1'b0;
            end
         end
         default: ;
      endcase
      main_d     = main_from_skid ? skid_q : in_payload;
      // in_ready mirrors the next skid valid bit, flush included.
      in_ready_d = ~(skid_vin & ~flush);
   end

   xm_slot #(.W(PAYLOAD_W)) u_main (
      .clock     (clock),
      .reset     (reset),
      .load      (main_load),
      .valid_in  (main_vin),
      .kill      (flush),
      .d         (main_d),
      .valid_out (main_valid),
      .q_out     (main_q)
   );

   xm_slot #(.W(PAYLOAD_W)) u_skid (
      .clock     (clock),
      .reset     (reset),
      .load      (skid_load),
      .valid_in  (skid_vin),
      .kill      (flush),
      .d         (in_payload),
      .valid_out (skid_valid),
      .q_out     (skid_q)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) in_ready_q <= 1'b1;
      else       in_ready_q <= in_ready_d;
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = main_valid;
   // Bubble gating so a valid-unaware consumer sees a NOP.
   assign ir_out        = main_valid ? main_q[IR_MSB -: IR_W] : NOP_IR;
   assign isRStatus_out = main_valid & main_q[0];
   assign o_out         = main_q[O_MSB -: DATA_W];
   assign b_out         = main_q[B_MSB -: DATA_W];
   assign rStatus_out   = main_q[RS_MSB -: DATA_W];

`ifdef LATCH_XM_PERF_EN
   logic [31:0] stall_cnt_d, stall_cnt_q;
   logic [31:0] flush_cnt_d, flush_cnt_q;

   // Counters wrap naturally at 2^32.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (main_valid && !out_ready)         stall_cnt_d = stall_cnt_q + 32'(1);
      if (flush && (main_valid || skid_valid)) flush_cnt_d = flush_cnt_q + 32'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_latch_xm_skid.sv
// Self-checking bench for latch_xm_skid: directed table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_latch_xm_skid;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock, reset;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] ir_in, o_in, b_in, rStatus_in;
   logic [31:0] ir_out, o_out, b_out, rStatus_out;
   logic        isRStatus_in, isRStatus_out;
`ifdef LATCH_XM_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   latch_xm_skid #(.DATA_W(32), .IR_W(32), .NOP_IR(NOP)) dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .ir_in         (ir_in),
      .o_in          (o_in),
      .b_in          (b_in),
      .isRStatus_in  (isRStatus_in),
      .rStatus_in    (rStatus_in),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .ir_out        (ir_out),
      .o_out         (o_out),
      .b_out         (b_out),
      .rStatus_out   (rStatus_out),
      .isRStatus_out (isRStatus_out)
`ifdef LATCH_XM_PERF_EN
     ,.stall_cnt     (stall_cnt)
     ,.flush_cnt     (flush_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model: a FIFO of at most two entries --------
   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] o;
      logic [31:0] b;
      logic [31:0] rs;
      logic        isr;
   } pl_t;

   pl_t         mq[$];
   int unsigned m_stall, m_flush;
   int          n_chk, n_fail;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_stall = 0;
      m_flush = 0;
   endtask

   // Advance the model by one clock using the inputs presented this cycle.
   task automatic model_edge(input logic iv, input logic ordy, input logic fl, input pl_t p);
      bit a, d;
      a = iv && (mq.size() < 2);
      d = (mq.size() > 0) && ordy;
      if (mq.size() > 0 && !ordy) m_stall++;
      if (fl && mq.size() > 0)   m_flush++;
      if (fl) mq.delete();
      else begin
         if (d) void'(mq.pop_front());
         if (a) mq.push_back(p);
      end
   endtask

   task automatic model_check();
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
      if (mq.size() > 0) begin
         chk("ir_out",        64'(ir_out),        64'(mq[0].ir));
         chk("o_out",         64'(o_out),         64'(mq[0].o));
         chk("b_out",         64'(b_out),         64'(mq[0].b));
         chk("rStatus_out",   64'(rStatus_out),   64'(mq[0].rs));
         chk("isRStatus_out", 64'(isRStatus_out), 64'(mq[0].isr));
      end else begin
         chk("ir_out_nop",    64'(ir_out),        64'(NOP));
         chk("isr_bubble",    64'(isRStatus_out), 64'(0));
      end
`ifdef LATCH_XM_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
   endtask

   // Present inputs, step model and DUT one edge, leave time at edge+1.
   task automatic cyc(input logic iv, input logic ordy, input logic fl, input pl_t p);
      in_valid     = iv;
      out_ready    = ordy;
      flush        = fl;
      ir_in        = p.ir;
      o_in         = p.o;
      b_in         = p.b;
      rStatus_in   = p.rs;
      isRStatus_in = p.isr;
      model_edge(iv, ordy, fl, p);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      ir_in = '0; o_in = '0; b_in = '0; rStatus_in = '0; isRStatus_in = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   function automatic pl_t mk(input logic [31:0] ir);
      pl_t p;
      p.ir = ir; p.o = ir + 32'd1; p.b = ir + 32'd2; p.rs = ir + 32'd3; p.isr = 1'b1;
      return p;
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        iv, ordy, fl;
      logic [31:0] ir;
      logic        e_ov, e_rdy;
      logic [31:0] e_ir;
   } vec_t;

   vec_t tbl[16];
   pl_t  zp;

   initial begin
      n_chk = 0;
      n_fail = 0;
      zp = '0;
      //            iv    ordy  fl    ir          ov    rdy   ir_out
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 32'h11};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 32'h22};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 32'h33};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, NOP};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'hA1, 1'b1, 1'b1, 32'hA1};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'hA2, 1'b1, 1'b0, 32'hA1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h5A, 1'b1, 1'b0, 32'hA1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'hA2};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, NOP};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'hC1, 1'b1, 1'b1, 32'hC1};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 32'hC2, 1'b1, 1'b0, 32'hC1};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 32'hB0, 1'b0, 1'b1, NOP};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, NOP};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 32'hD1, 1'b1, 1'b1, 32'hD1};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 32'hD2, 1'b0, 1'b1, NOP};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, NOP};

      // Reset state
      do_reset();
      reset = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid),     64'(0));
      chk("rst_in_ready",  64'(in_ready),      64'(1));
      chk("rst_ir_out",    64'(ir_out),        64'(NOP));
      chk("rst_isr",       64'(isRStatus_out), 64'(0));
      chk("rst_o_out",     64'(o_out),         64'(0));
`ifdef LATCH_XM_PERF_EN
      chk("rst_stall_cnt", 64'(stall_cnt),     64'(0));
      chk("rst_flush_cnt", 64'(flush_cnt),     64'(0));
`endif
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b0, zp);
         model_check();
      end

      // Directed table
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].iv, tbl[i].ordy, tbl[i].fl, mk(tbl[i].ir));
         chk($sformatf("tbl%0d_ov", i),  64'(out_valid),     64'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_rdy", i), 64'(in_ready),      64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_ir", i),  64'(ir_out),        64'(tbl[i].e_ir));
         chk($sformatf("tbl%0d_isr", i), 64'(isRStatus_out), 64'(tbl[i].e_ov));
         if (tbl[i].e_ov)
            chk($sformatf("tbl%0d_o", i), 64'(o_out), 64'(tbl[i].e_ir + 32'd1));
      end

      // Asynchronous reset mid-cycle drops the held entry before the next edge
      do_reset();
      begin
         pl_t p;
         p = '{ir: 32'hC0, o: 32'h1, b: 32'h2, rs: 32'hDEAD, isr: 1'b1};
         cyc(1'b1, 1'b0, 1'b0, p);
      end
      chk("ar_pre_ov",  64'(out_valid),     64'(1));
      chk("ar_pre_isr", 64'(isRStatus_out), 64'(1));
      chk("ar_pre_rs",  64'(rStatus_out),   64'(32'hDEAD));
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("ar_ov",  64'(out_valid),     64'(0));
      chk("ar_isr", 64'(isRStatus_out), 64'(0));
      chk("ar_ir",  64'(ir_out),        64'(NOP));
      chk("ar_rdy", 64'(in_ready),      64'(1));
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();

      // Stall then flush: 5 stalled cycles, one flush of a valid entry
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, mk(32'hE0));
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, zp);
      chk("pf_ov_held", 64'(out_valid), 64'(1));
      chk("pf_ir_held", 64'(ir_out),    64'(32'hE0));
      cyc(1'b0, 1'b1, 1'b1, zp);
      chk("pf_ov_flushed", 64'(out_valid), 64'(0));
`ifdef LATCH_XM_PERF_EN
      chk("pf_stall_cnt", 64'(stall_cnt), 64'(5));
      chk("pf_flush_cnt", 64'(flush_cnt), 64'(1));
`endif
      // Flush of an empty latch must not count
      cyc(1'b0, 1'b1, 1'b1, zp);
`ifdef LATCH_XM_PERF_EN
      chk("pf_flush_empty", 64'(flush_cnt), 64'(1));
`endif

      // Randomized run against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         pl_t p;
         logic iv, ordy, fl;
         p.ir  = $urandom;
         p.o   = $urandom;
         p.b   = $urandom;
         p.rs  = $urandom;
         p.isr = 1'($urandom_range(0, 1));
         iv    = ($urandom_range(0, 3) != 0);
         ordy  = ($urandom_range(0, 2) != 0);
         fl    = ($urandom_range(0, 15) == 0);
         cyc(iv, ordy, fl, p);
         model_check();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/latch_xm_skid.md
Name: latch_xm_skid

Overview:
- Parametrised successor to the fixed X/M pipeline latch, sitting between the execute and memory stages.
- Carries ir, o, b, rStatus and isRStatus, and adds a valid/ready handshake, a 2-entry skid buffer for stall absorption, synchronous flush, and NOP injection on bubbles.
- Lets the memory stage back-pressure execute without a combinational ready path through the latch.

Parameters:
- DATA_W, 32, width of o, b and rStatus.
- IR_W, 32, width of the instruction register field.
- NOP_IR, {IR_W{1'b0}}, instruction word driven on ir_out whenever out_valid is 0.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  execute stage presents a valid instruction
- in_ready  output  1  latch can accept this cycle (registered)
- ir_in  input  IR_W  instruction from execute
- o_in  input  DATA_W  ALU result / address
- b_in  input  DATA_W  store data
- isRStatus_in  input  1  instruction writes rStatus
- rStatus_in  input  DATA_W  status value
- flush  input  1  synchronous kill of all held entries
- out_valid  output  1  memory stage sees a valid instruction
- out_ready  input  1  memory stage consumes this cycle
- ir_out  output  IR_W  held instruction, or NOP_IR when out_valid=0
- o_out, b_out, rStatus_out  output  DATA_W  held payload
- isRStatus_out  output  1  held flag, forced 0 when out_valid=0

Behaviour:
- Clocking and reset:
  - One clock domain; all state updates on the rising edge of clock.
  - reset is asynchronous and active-high.
- Storage: main slot (drives the outputs) and skid slot, each holding a payload plus a valid bit.
- Occupancy states:
  - EMPTY (main=0, skid=0)
  - ONE (main=1, skid=0)
  - FULL (main=1, skid=1)
- Handshake rules:
  - in_ready = ~skid_valid, taken directly from a flop. It is 1 in EMPTY and ONE, 0 in FULL.
  - acc = in_valid & in_ready.
  - deq = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY, acc → ONE; main loads the input.
  - ONE, acc & deq → ONE; main loads the input.
  - ONE, acc & ~deq → FULL; skid loads the input.
  - ONE, ~acc & deq → EMPTY.
  - FULL, deq → ONE; main loads skid. No accept is possible because in_ready=0.
  - Any other combination holds state.
- Latency and throughput:
  - Accept-to-out_valid latency is 1 cycle.
  - Sustained throughput is 1/cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry is always younger than the main entry.
- Flush:
  - Clears both valid bits next edge → EMPTY.
  - An input accepted in the same cycle is discarded.
  - flush wins over acc and deq.
  - in_ready is 1 the cycle after.
- Output gating:
  - out_valid = main_valid.
  - When out_valid=0: ir_out=NOP_IR and isRStatus_out=0, so a valid-unaware downstream sees a bubble.
  - o_out, b_out and rStatus_out hold their last values when out_valid=0 (don't-care).
- Reset values, applied asynchronously:
  - all valids 0, so out_valid=0 and in_ready=1
  - all payload flops 0
  - ir_out=NOP_IR
- Reset mid-operation drops all held instructions.
- Payload flops need no reset for correctness, but are reset for deterministic simulation.

Optional Feature:
- Macro: LATCH_XM_PERF_EN.
- When defined:
  - Adds output stall_cnt[31:0], incremented each cycle with out_valid & ~out_ready.
  - Adds output flush_cnt[31:0], incremented each cycle a flush kills at least one valid entry.
  - Both counters wrap at 2^32 and are cleared by reset.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - state encodings EMPTY=2'b00, ONE=2'b01, FULL=2'b11
  - the default NOP_IR constant
  - the payload bit-width sum, PAYLOAD_W = IR_W + 3*DATA_W + 1
- Payload fields are concatenated into one PAYLOAD_W vector internally.
- Natural sub-module: xm_slot, a PAYLOAD_W register with load enable, valid flop, asynchronous reset and synchronous kill. It is instantiated twice (main, skid).

Test Plan:
- Reset → out_valid=0, in_ready=1, ir_out=NOP_IR, isRStatus_out=0; release reset with in_valid=0 and all outputs hold.
- Stream ir=0x11,0x22,0x33 on consecutive cycles with out_ready=1 → ir_out shows 0x11,0x22,0x33 one cycle after each accept; in_ready stays 1.
- Accept 0xA1 (goes to main); next cycle present 0xA2 and drop out_ready (0xA2 goes to skid). Next:
  - state FULL and in_ready=0 from the following edge;
  - ir_out holds 0xA1;
  - raising out_ready drains 0xA1 then 0xA2 in order.
- In FULL, assert flush together with in_valid (ir=0xB0) → next cycle out_valid=0, ir_out=NOP_IR, in_ready=1, and 0xB0 never appears.
- Accept ir=0xC0 with isRStatus_in=1 and rStatus_in=0xDEAD; assert reset asynchronously mid-cycle → out_valid and isRStatus_out drop immediately, before the next edge.
- With LATCH_XM_PERF_EN defined: hold out_ready=0 for 5 cycles with one valid entry, then flush → stall_cnt=5, flush_cnt=1.
